// File: rtl/hard_mem_1rw_bit_mask_arb_ctrl.sv
// rtl/hard_mem_1rw_bit_mask_arb_ctrl.sv - zero-fill sequencer and round-robin arbiter for a 1RW bit-mask SRAM
module hard_mem_1rw_bit_mask_arb_ctrl #(
  parameter int width_p       = 96,
  parameter int els_p         = 64,
  localparam int addr_width_lp = $clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     clear_i,
  output logic                     clear_done_o,

  input  logic                     req0_v_i,
  output logic                     req0_ready_o,
  input  logic                     req0_w_i,
  input  logic [addr_width_lp-1:0] req0_addr_i,
  input  logic [width_p-1:0]       req0_data_i,
  input  logic [width_p-1:0]       req0_mask_i,

  input  logic                     req1_v_i,
  output logic                     req1_ready_o,
  input  logic                     req1_w_i,
  input  logic [addr_width_lp-1:0] req1_addr_i,
  input  logic [width_p-1:0]       req1_data_i,
  input  logic [width_p-1:0]       req1_mask_i,

  output logic                     rsp0_v_o,
  output logic                     rsp1_v_o,
  output logic [width_p-1:0]       rsp_data_o,

  output logic                     mem_v_o,
  output logic                     mem_w_o,
  output logic [addr_width_lp-1:0] mem_addr_o,
  output logic [width_p-1:0]       mem_data_o,
  output logic [width_p-1:0]       mem_w_mask_o,
  input  logic [width_p-1:0]       mem_data_i
);

  typedef enum logic {clear_s, ready_s} state_e;

  localparam logic [addr_width_lp:0] last_cnt_lp = (addr_width_lp+1)'(els_p - 1);

  state_e                  state_r;
  logic [addr_width_lp:0]  clear_cnt_r;
  logic                    last_grant_r;
  logic                    rsp0_v_r, rsp1_v_r;
  logic                    grant0, grant1;

  // Both valid: the port that did not win last time gets the slot.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_r == ready_s && !clear_i) begin
      grant0 = req0_v_i & (~req1_v_i | last_grant_r);
      grant1 = req1_v_i & (~req0_v_i | ~last_grant_r);
    end
  end

  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;
  assign clear_done_o = (state_r == ready_s);

  always_comb begin
    mem_v_o      = 1'b0;
    mem_w_o      = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    mem_w_mask_o = '0;
    if (state_r == clear_s) begin
      mem_v_o    = 1'b1;
      mem_w_o    = 1'b1;
      mem_addr_o = clear_cnt_r[addr_width_lp-1:0];
    end else if (grant0) begin
      mem_v_o      = 1'b1;
      mem_w_o      = req0_w_i;
      mem_addr_o   = req0_addr_i;
      mem_data_o   = req0_data_i;
      mem_w_mask_o = req0_mask_i;
    end else if (grant1) begin
      mem_v_o      = 1'b1;
      mem_w_o      = req1_w_i;
      mem_addr_o   = req1_addr_i;
      mem_data_o   = req1_data_i;
      mem_w_mask_o = req1_mask_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r      <= clear_s;
      clear_cnt_r  <= '0;
      last_grant_r <= 1'b1;
      rsp0_v_r     <= 1'b0;
      rsp1_v_r     <= 1'b0;
    end else begin
      rsp0_v_r <= grant0 & ~req0_w_i;
      rsp1_v_r <= grant1 & ~req1_w_i;
      case (state_r)
        clear_s: begin
          if (clear_cnt_r == last_cnt_lp) begin
            state_r     <= ready_s;
            clear_cnt_r <= '0;
          end else begin
            clear_cnt_r <= clear_cnt_r + 1'b1;
          end
        end
        default: begin
          if (clear_i) begin
            state_r     <= clear_s;
            clear_cnt_r <= '0;
          end else if (grant0 | grant1) begin
            last_grant_r <= grant1;
          end
        end
      endcase
    end
  end

  // A reset arriving right after an accepted read kills its response.
  assign rsp0_v_o   = rsp0_v_r & ~reset_i;
  assign rsp1_v_o   = rsp1_v_r & ~reset_i;
  assign rsp_data_o = mem_data_i;

endmodule

// File: tb/tb_hard_mem_1rw_bit_mask_arb_ctrl.sv
// tb/tb_hard_mem_1rw_bit_mask_arb_ctrl.sv - bench for hard_mem_1rw_bit_mask_arb_ctrl
module tb_hard_mem_1rw_bit_mask_arb_ctrl;
  localparam int W = 96;
  localparam int N = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_i, clear_i, clear_done_o;
  logic rv[2], rw[2], rdy[2];
  logic [5:0] ra[2];
  logic [W-1:0] rd[2], rm[2];
  logic rsp0_v_o, rsp1_v_o;
  logic [W-1:0] rsp_data_o;
  logic mem_v_o, mem_w_o;
  logic [5:0] mem_addr_o;
  logic [W-1:0] mem_data_o, mem_w_mask_o, sram_q;

  hard_mem_1rw_bit_mask_arb_ctrl #(.width_p(W), .els_p(N)) dut (
    .clk_i(clk), .reset_i(reset_i), .clear_i(clear_i), .clear_done_o(clear_done_o),
    .req0_v_i(rv[0]), .req0_ready_o(rdy[0]), .req0_w_i(rw[0]), .req0_addr_i(ra[0]),
    .req0_data_i(rd[0]), .req0_mask_i(rm[0]),
    .req1_v_i(rv[1]), .req1_ready_o(rdy[1]), .req1_w_i(rw[1]), .req1_addr_i(ra[1]),
    .req1_data_i(rd[1]), .req1_mask_i(rm[1]),
    .rsp0_v_o(rsp0_v_o), .rsp1_v_o(rsp1_v_o), .rsp_data_o(rsp_data_o),
    .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_w_mask_o(mem_w_mask_o), .mem_data_i(sram_q)
  );

  // 1RW SRAM with low-true bit mask and registered read data
  logic [W-1:0] sram [N];
  always @(posedge clk) begin
    if (mem_v_o) begin
      if (mem_w_o) sram[mem_addr_o] <= (sram[mem_addr_o] & mem_w_mask_o) | (mem_data_o & ~mem_w_mask_o);
      else         sram_q <= sram[mem_addr_o];
    end
  end

  int checks = 0;
  int errors = 0;

  // reference model state
  bit m_valid = 0;
  bit m_ready;
  int m_cnt, m_last, m_rsp;
  logic [W-1:0] m_rsp_data;
  logic [W-1:0] ref_mem [N];

  logic obs_rdy[2], obs_rsp[2], obs_done;
  logic [W-1:0] obs_rdata;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic zero_ref();
    for (int i = 0; i < N; i++) ref_mem[i] = '0;
  endtask

  // One clock: check all outputs at the negedge against the model, then advance the model.
  task automatic cycle();
    int gp;
    bit ev, ew;
    int ea;
    logic [W-1:0] ed, em;
    @(negedge clk);
    gp = -1;
    if (m_ready && !clear_i) begin
      if (rv[0] && rv[1]) gp = (m_last == 0) ? 1 : 0;
      else if (rv[0])     gp = 0;
      else if (rv[1])     gp = 1;
    end
    ev = 0; ew = 0; ea = 0; ed = '0; em = '0;
    if (!m_ready) begin
      ev = 1; ew = 1; ea = m_cnt;
    end else if (gp >= 0) begin
      ev = 1; ew = rw[gp]; ea = int'(ra[gp]); ed = rd[gp]; em = rm[gp];
    end
    obs_rdy[0] = rdy[0];  obs_rdy[1] = rdy[1];
    obs_rsp[0] = rsp0_v_o; obs_rsp[1] = rsp1_v_o;
    obs_done = clear_done_o; obs_rdata = rsp_data_o;
    if (m_valid) begin
      chk1("clear_done", clear_done_o, m_ready);
      chk1("req0_ready", rdy[0], gp == 0);
      chk1("req1_ready", rdy[1], gp == 1);
      chk1("mem_v", mem_v_o, ev);
      chk1("mem_w", mem_w_o, ew);
      chki("mem_addr", int'(mem_addr_o), ea);
      chkw("mem_data", mem_data_o, ed);
      chkw("mem_mask", mem_w_mask_o, em);
      chk1("rsp0_v", rsp0_v_o, m_rsp == 0 && !reset_i);
      chk1("rsp1_v", rsp1_v_o, m_rsp == 1 && !reset_i);
      if (m_rsp >= 0 && !reset_i) chkw("rsp_data", rsp_data_o, m_rsp_data);
    end
    if (reset_i) begin
      m_valid = 1; m_ready = 0; m_cnt = 0; m_last = 1; m_rsp = -1;
      zero_ref();
    end else if (!m_ready) begin
      m_rsp = -1;
      if (m_cnt == N - 1) begin m_ready = 1; m_cnt = 0; end
      else m_cnt++;
    end else if (clear_i) begin
      m_ready = 0; m_cnt = 0; m_rsp = -1;
      zero_ref();
    end else begin
      m_rsp = -1;
      if (gp >= 0) begin
        m_last = gp;
        if (rw[gp]) ref_mem[ra[gp]] = (ref_mem[ra[gp]] & rm[gp]) | (rd[gp] & ~rm[gp]);
        else begin m_rsp = gp; m_rsp_data = ref_mem[ra[gp]]; end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input bit v, input bit w, input int a,
                         input logic [W-1:0] d, input logic [W-1:0] m);
    rv[p] = v; rw[p] = w; ra[p] = a[5:0]; rd[p] = d; rm[p] = m;
  endtask

  task automatic count_clear(output int n);
    bit seen;
    n = 0; seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      cycle();
      if (obs_done) seen = 1; else n++;
    end
  endtask

  initial begin
    int n, prev, g;
    logic [W-1:0] ones;
    ones = '1;
    reset_i = 1; clear_i = 0;
    for (int p = 0; p < 2; p++) set_req(p, 0, 0, 0, '0, '0);
    @(posedge clk); #1;
    cycle(); cycle();

    // 1: full zero-fill after reset
    reset_i = 0;
    count_clear(n);
    chki("t1_clear_len", n, 64);

    // 2: write then read back
    set_req(0, 1, 1, 5, W'('hA5), '0); cycle();
    chk1("t2_wr_acc", obs_rdy[0], 1'b1);
    set_req(0, 1, 0, 5, '0, ones); cycle();
    chk1("t2_rd_acc", obs_rdy[0], 1'b1);
    set_req(0, 0, 0, 0, '0, '0); cycle();
    chk1("t2_rsp_v", obs_rsp[0], 1'b1);
    chkw("t2_rsp_data", obs_rdata, W'('hA5));

    // 3: both reading continuously -> alternation
    set_req(0, 1, 0, 5, '0, ones);
    set_req(1, 1, 0, 7, '0, ones);
    prev = -1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      g = obs_rdy[1] ? 1 : 0;
      chk1("t3_one_grant", obs_rdy[0] ^ obs_rdy[1], 1'b1);
      if (prev >= 0) begin
        chk1("t3_alternate", g != prev, 1'b1);
        chk1("t3_rsp_port", obs_rsp[prev], 1'b1);
      end
      prev = g;
    end
    set_req(0, 0, 0, 0, '0, '0); set_req(1, 0, 0, 0, '0, '0); cycle();

    // 4: partial mask
    set_req(1, 1, 1, 3, W'('hFF), '0); cycle();
    set_req(1, 1, 1, 3, '0, ones << 4); cycle();
    set_req(1, 1, 0, 3, '0, ones); cycle();
    set_req(1, 0, 0, 0, '0, '0); cycle();
    chk1("t4_rsp_v", obs_rsp[1], 1'b1);
    chkw("t4_rsp_data", obs_rdata, W'('hF0));

    // 5: read just before clear still responds; req1 stalls across the clear
    set_req(0, 1, 0, 3, '0, ones); cycle();
    set_req(0, 0, 0, 0, '0, '0);
    clear_i = 1; set_req(1, 1, 0, 5, '0, ones); cycle();
    chk1("t5_rsp_pre_clear", obs_rsp[0], 1'b1);
    chkw("t5_rsp_pre_data", obs_rdata, W'('hF0));
    chk1("t5_no_grant", obs_rdy[1], 1'b0);
    clear_i = 0; n = 0;
    for (int k = 0; k < 200 && !obs_rdy[1]; k++) begin
      clear_i = (k == 10);
      cycle();
      if (!obs_rdy[1]) n++;
    end
    clear_i = 0;
    chki("t5_stall_len", n, 64);
    set_req(1, 0, 0, 0, '0, '0); cycle();
    chk1("t5_rsp_v", obs_rsp[1], 1'b1);
    chkw("t5_rsp_zero", obs_rdata, '0);

    // 6: reset right after a read, then reset mid-clear
    set_req(0, 1, 0, 5, '0, ones); cycle();
    set_req(0, 0, 0, 0, '0, '0);
    reset_i = 1; cycle();
    chk1("t6_rsp_suppressed", obs_rsp[0], 1'b0);
    reset_i = 0;
    repeat (30) cycle();
    reset_i = 1; cycle();
    reset_i = 0;
    count_clear(n);
    chki("t6_restart_len", n, 64);

    // random traffic, requests held until accepted
    for (int k = 0; k < 800; k++) begin
      clear_i = ($urandom_range(0, 59) == 0);
      cycle();
      for (int p = 0; p < 2; p++) begin
        if (obs_rdy[p] || !rv[p]) begin
          if ($urandom_range(0, 9) < 7)
            set_req(p, 1, $urandom_range(0, 1) == 1, $urandom_range(0, N - 1),
                    {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom});
          else
            rv[p] = 0;
        end
      end
    end
    clear_i = 0;
    set_req(0, 0, 0, 0, '0, '0); set_req(1, 0, 0, 0, '0, '0);
    cycle(); cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
